// File: rtl/bg_ocm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bg_ocm_arbiter_if
//  Description : Bundle of the background-memory arbiter's pixel, auxiliary
//                and memory-side signals. The "slave" modport is the arbiter.
//                The "master" modport is everything around it: color mapper,
//                game-logic readers and the vga_port memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bg_ocm_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NREQ   = 4
);
    logic                     blank;
    logic [ADDR_W-1:0]        pix_addr;
    logic [DATA_W-1:0]        pix_data;
    logic                     pix_valid;
    logic [NREQ-1:0]          req;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ-1:0]          ack;
    logic [NREQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_rdata;

    modport master (
        output blank, pix_addr, req, req_addr, mem_rdata,
        input  pix_data, pix_valid, ack, rsp_valid, rsp_data, mem_addr
    );

    modport slave (
        input  blank, pix_addr, req, req_addr, mem_rdata,
        output pix_data, pix_valid, ack, rsp_valid, rsp_data, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/bg_ocm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bg_ocm_arbiter
//  Description : Shares the background on-chip memory read port between the
//                per-pixel fetch (absolute priority while blank=1) and NREQ
//                auxiliary readers, which are served round-robin during
//                blanking. A tag pipeline matched to RD_LAT routes each read
//                result back to its owner RD_LAT+1 cycles after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module bg_ocm_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NREQ   = 4,
    parameter int RD_LAT = 2
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    bg_ocm_arbiter_if.slave   bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Issue stage: registered alongside mem_addr, describes the read now on the bus.
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NREQ-1:0]   r_ack;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_iss_vld;
    logic              r_iss_pix;
    logic [PTR_W-1:0]  r_iss_idx;

    // RD_LAT-deep tag shift register following the issue stage.
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_pix;
    logic [PTR_W-1:0]  r_pipe_idx [RD_LAT];

    logic [DATA_W-1:0] r_pix_data;
    logic              r_pix_valid;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic [NREQ-1:0]   w_elig;
    logic              w_found;
    logic [PTR_W-1:0]  w_win;
    logic [PTR_W-1:0]  w_idx;
    logic [NREQ-1:0]   w_grant;
    logic [ADDR_W-1:0] w_addr;

    // Round-robin search from rr_ptr+1; a requester granted last cycle is
    // masked out because it has not yet seen its ack and still holds req.
    always_comb begin
        w_elig  = bus.req & ~r_ack;
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_grant = NREQ'(1) << w_win;
        w_addr  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Arbitration: pixel fetch wins whenever blank=1, otherwise one aux grant.
    // With nothing to issue the address bus holds and a NONE tag is issued.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mem_addr <= '0;
            r_ack      <= '0;
            r_rr_ptr   <= PTR_W'(NREQ - 1);
            r_iss_vld  <= 1'b0;
            r_iss_pix  <= 1'b0;
            r_iss_idx  <= '0;
        end else if (bus.blank) begin
            r_mem_addr <= bus.pix_addr;
            r_ack      <= '0;
            r_iss_vld  <= 1'b1;
            r_iss_pix  <= 1'b1;
            r_iss_idx  <= '0;
        end else if (w_found) begin
            r_mem_addr <= w_addr;
            r_ack      <= w_grant;
            r_rr_ptr   <= w_win;
            r_iss_vld  <= 1'b1;
            r_iss_pix  <= 1'b0;
            r_iss_idx  <= w_win;
        end else begin
            r_ack      <= '0;
            r_iss_vld  <= 1'b0;
            r_iss_pix  <= 1'b0;
        end
    end

    // Tag pipeline: the last stage lines up with mem_rdata being valid.
    // Clearing it on Reset drops every read already in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pipe_vld <= '0;
            r_pipe_pix <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_idx[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= r_iss_vld;
            r_pipe_pix[0] <= r_iss_pix;
            r_pipe_idx[0] <= r_iss_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_pix[k] <= r_pipe_pix[k-1];
                r_pipe_idx[k] <= r_pipe_idx[k-1];
            end
        end
    end

    // Response capture: route mem_rdata to its owner; data registers hold
    // their last value between pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_pix_valid <= r_pipe_vld[RD_LAT-1] & r_pipe_pix[RD_LAT-1];
            r_rsp_valid <= '0;
            if (r_pipe_vld[RD_LAT-1]) begin
                if (r_pipe_pix[RD_LAT-1]) begin
                    r_pix_data <= bus.mem_rdata;
                end else begin
                    r_rsp_valid <= NREQ'(1) << r_pipe_idx[RD_LAT-1];
                    r_rsp_data  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.ack       = r_ack;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_data  = r_pix_data;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
